poly_basemul_unit: RTL and testbench

Responder side of the basemul handshake issued by the polyvec accumulate controller. Buffers one 128-word polynomial pair (A, B) streamed in under controller strobes, computes the Kyber NTT-domain base multiplication with Montgomery reduction into a result buffer C, signals completion on `done`, and streams C back out under `readout`. Sits between the controller and the coefficient RAMs A/B/C.

---
 rtl/kyber_pkg.sv | 83 ++++++++
 rtl/mont_reduce.sv | 14 +
 rtl/poly_basemul_unit.sv | 122 ++++++++++++
 tb/tb_poly_basemul_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// kyber_pkg: Kyber modulus constants, coefficient type, controller states and
// the signed Montgomery-form zeta ROM shared by the basemul datapath.
package kyber_pkg;
  localparam int KYBER_Q = 3329;
  localparam int QINV = 62209;
  localparam int COEF_W = 16;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef enum logic [1:0] {IDLE, CALC, DRAIN} state_e;
  function automatic logic signed [31:0] sx(input coef_t x);
    return 32'(x);
  endfunction
  function automatic coef_t zeta(input logic [6:0] k);
    int z;
    case (k)
      7'd0: z = -1044;    7'd1: z = -758;
      7'd2: z = -359;     7'd3: z = -1517;
      7'd4: z = 1493;     7'd5: z = 1422;
      7'd6: z = 287;      7'd7: z = 202;
      7'd8: z = -171;     7'd9: z = 622;
      7'd10: z = 1577;    7'd11: z = 182;
      7'd12: z = 962;     7'd13: z = -1202;
      7'd14: z = -1474;   7'd15: z = 1468;
      7'd16: z = 573;     7'd17: z = -1325;
      7'd18: z = 264;     7'd19: z = 383;
      7'd20: z = -829;    7'd21: z = 1458;
      7'd22: z = -1602;   7'd23: z = -130;
      7'd24: z = -681;    7'd25: z = 1017;
      7'd26: z = 732;     7'd27: z = 608;
      7'd28: z = -1542;   7'd29: z = 411;
      7'd30: z = -205;    7'd31: z = -1571;
      7'd32: z = 1223;    7'd33: z = 652;
      7'd34: z = -552;    7'd35: z = 1015;
      7'd36: z = -1293;   7'd37: z = 1491;
      7'd38: z = -282;    7'd39: z = -1544;
      7'd40: z = 516;     7'd41: z = -8;
      7'd42: z = -320;    7'd43: z = -666;
      7'd44: z = -1618;   7'd45: z = -1162;
      7'd46: z = 126;     7'd47: z = 1469;
      7'd48: z = -853;    7'd49: z = -90;
      7'd50: z = -271;    7'd51: z = 830;
      7'd52: z = 107;     7'd53: z = -1421;
      7'd54: z = -247;    7'd55: z = -951;
      7'd56: z = -398;    7'd57: z = 961;
      7'd58: z = -1508;   7'd59: z = -725;
      7'd60: z = 448;     7'd61: z = -1065;
      7'd62: z = 677;     7'd63: z = -1275;
      7'd64: z = -1103;   7'd65: z = 430;
      7'd66: z = 555;     7'd67: z = 843;
      7'd68: z = -1251;   7'd69: z = 871;
      7'd70: z = 1550;    7'd71: z = 105;
      7'd72: z = 422;     7'd73: z = 587;
      7'd74: z = 177;     7'd75: z = -235;
      7'd76: z = -291;    7'd77: z = -460;
      7'd78: z = 1574;    7'd79: z = 1653;
      7'd80: z = -246;    7'd81: z = 778;
      7'd82: z = 1159;    7'd83: z = -147;
      7'd84: z = -777;    7'd85: z = 1483;
      7'd86: z = -602;    7'd87: z = 1119;
      7'd88: z = -1590;   7'd89: z = 644;
      7'd90: z = -872;    7'd91: z = 349;
      7'd92: z = 418;     7'd93: z = 329;
      7'd94: z = -156;    7'd95: z = -75;
      7'd96: z = 817;     7'd97: z = 1097;
      7'd98: z = 603;     7'd99: z = 610;
      7'd100: z = 1322;   7'd101: z = -1285;
      7'd102: z = -1465;  7'd103: z = 384;
      7'd104: z = -1215;  7'd105: z = -136;
      7'd106: z = 1218;   7'd107: z = -1335;
      7'd108: z = -874;   7'd109: z = 220;
      7'd110: z = -1187;  7'd111: z = -1659;
      7'd112: z = -1185;  7'd113: z = -1530;
      7'd114: z = -1278;  7'd115: z = 794;
      7'd116: z = -1510;  7'd117: z = -854;
      7'd118: z = -870;   7'd119: z = 478;
      7'd120: z = -108;   7'd121: z = -308;
      7'd122: z = 996;    7'd123: z = 991;
      7'd124: z = 958;    7'd125: z = -1460;
      7'd126: z = 1522;   7'd127: z = 1628;
      default: z = 0;
    endcase
    return coef_t'(z);
  endfunction
endpackage

// File: rtl/mont_reduce.sv
// mont_reduce: signed Montgomery reduction, t * 2^-16 mod q for a 32-bit product.
module mont_reduce
  import kyber_pkg::*;
(
  input  logic signed [31:0] t_i,
  output coef_t              r_o
);
  logic [15:0] u;
  logic signed [31:0] d;
  assign u = t_i[15:0] * 16'(QINV);
  // low half of d is zero by construction, so the high half is the exact quotient
  assign d = t_i - $signed({{16{u[15]}}, u}) * KYBER_Q;
  assign r_o = d[31:16];
endmodule

// File: rtl/poly_basemul_unit.sv
// poly_basemul_unit: buffers an (A, B) polynomial pair, computes Kyber NTT-domain
// base multiplication into C through a 3-stage pipeline and streams C back out.
module poly_basemul_unit
  import kyber_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set,
  input  logic        readin_a,
  input  logic        readin_b,
  input  logic [31:0] din_a,
  input  logic [31:0] din_b,
  input  logic        full_in_a,
  input  logic        full_in_b,
  input  logic        cal_en,
  input  logic        readout,
  output logic [31:0] dout,
  output logic        done
);
  localparam int AW = DEPTH - 1;
  localparam int N = 1 << AW;
  logic [31:0] buf_a [N];
  logic [31:0] buf_b [N];
  logic [31:0] buf_c [N];
  state_e state_q;
  logic [AW-1:0] wptr_a_q, wptr_b_q, rptr_q, j_q, idx1_q, idx2_q;
  logic full_a_q, full_b_q, v1_q, v2_q;
  logic [31:0] a_q, b_q;
  coef_t z1_q, z2_q, m00_q, m01_q, m10_q, m11_q;
  coef_t m00_d, m01_d, m10_d, m11_d, mz_d, zeta_d;
  logic wr_a, wr_b;
  assign wr_a = set && state_q == IDLE && readin_a;
  assign wr_b = set && state_q == IDLE && readin_b;
  // pair j uses zetas[64 + j/2]
  assign zeta_d = zeta({1'b1, j_q[AW-1:1]});
  mont_reduce u_m00 (.t_i(sx(a_q[15:0]) * sx(b_q[15:0])), .r_o(m00_d));
  mont_reduce u_m01 (.t_i(sx(a_q[15:0]) * sx(b_q[31:16])), .r_o(m01_d));
  mont_reduce u_m10 (.t_i(sx(a_q[31:16]) * sx(b_q[15:0])), .r_o(m10_d));
  mont_reduce u_m11 (.t_i(sx(a_q[31:16]) * sx(b_q[31:16])), .r_o(m11_d));
  mont_reduce u_mz (.t_i(sx(m11_q) * sx(z2_q)), .r_o(mz_d));
  always_ff @(posedge clk) begin
    if (wr_a) buf_a[wptr_a_q] <= din_a;
    if (wr_b) buf_b[wptr_b_q] <= din_b;
    if (set && v2_q) buf_c[idx2_q] <= {m01_q + m10_q, mz_d + m00_q};
    if (set) begin
      a_q <= buf_a[j_q];
      b_q <= buf_b[j_q];
      z1_q <= j_q[0] ? -zeta_d : zeta_d;
      idx1_q <= j_q;
      m00_q <= m00_d;
      m01_q <= m01_d;
      m10_q <= m10_d;
      m11_q <= m11_d;
      z2_q <= z1_q;
      idx2_q <= idx1_q;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      done <= 1'b0;
      dout <= '0;
      full_a_q <= 1'b0;
      full_b_q <= 1'b0;
      wptr_a_q <= '0;
      wptr_b_q <= '0;
      rptr_q <= '0;
      j_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else if (set) begin
      v1_q <= state_q == CALC;
      v2_q <= v1_q;
      if (readout) begin
        dout <= buf_c[rptr_q];
        rptr_q <= rptr_q + AW'(1);
      end
      case (state_q)
        IDLE: begin
          if (readin_a) wptr_a_q <= wptr_a_q + AW'(1);
          if (readin_b) wptr_b_q <= wptr_b_q + AW'(1);
          if (full_in_a) begin
            full_a_q <= 1'b1;
            wptr_a_q <= '0;
          end
          if (full_in_b) begin
            full_b_q <= 1'b1;
            wptr_b_q <= '0;
          end
          if (cal_en && full_a_q && full_b_q) begin
            done <= 1'b0;
            j_q <= '0;
            state_q <= CALC;
          end else if (cal_en) begin
            full_a_q <= 1'b0;
            full_b_q <= 1'b0;
            wptr_a_q <= '0;
            wptr_b_q <= '0;
            rptr_q <= '0;
          end
        end
        CALC: begin
          j_q <= j_q + AW'(1);
          if (&j_q) state_q <= DRAIN;
        end
        default: begin
          // j restarts at 0 on entry; two more edges flush S2/S3, the third finishes
          j_q <= j_q + AW'(1);
          if (j_q == AW'(2)) begin
            done <= 1'b1;
            full_a_q <= 1'b0;
            full_b_q <= 1'b0;
            rptr_q <= '0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_poly_basemul_unit.sv
// tb_poly_basemul_unit: directed bench; a golden basemul model fills a scoreboard
// that is compared word by word against the streamed-out C buffer.
module tb_poly_basemul_unit;
  localparam int Q = 3329;
  localparam int ZT [64] = '{
    -1103, 430, 555, 843, -1251, 871, 1550, 105,
    422, 587, 177, -235, -291, -460, 1574, 1653,
    -246, 778, 1159, -147, -777, 1483, -602, 1119,
    -1590, 644, -872, 349, 418, 329, -156, -75,
    817, 1097, 603, 610, 1322, -1285, -1465, 384,
    -1215, -136, 1218, -1335, -874, 220, -1187, -1659,
    -1185, -1530, -1278, 794, -1510, -854, -870, 478,
    -108, -308, 996, 991, 958, -1460, 1522, 1628};
  logic clk = 1'b0, reset = 1'b1, set = 1'b1;
  logic readin_a = 1'b0, readin_b = 1'b0, full_in_a = 1'b0, full_in_b = 1'b0;
  logic cal_en = 1'b0, readout = 1'b0, done;
  logic [31:0] din_a = '0, din_b = '0, dout;
  logic [31:0] ma [128], mb [128], gold [128], rd [128];
  logic [31:0] exp_q [$];
  int checks = 0, failures = 0, lat;
  poly_basemul_unit #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset), .set(set),
    .readin_a(readin_a), .readin_b(readin_b), .din_a(din_a), .din_b(din_b),
    .full_in_a(full_in_a), .full_in_b(full_in_b), .cal_en(cal_en),
    .readout(readout), .dout(dout), .done(done)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic int mr(input int t);
    logic signed [15:0] u;
    u = 16'(t * 62209);
    return (t - int'(u) * Q) >>> 16;
  endfunction
  function automatic int md(input int x);
    return ((x % Q) + Q) % Q;
  endfunction
  function automatic int lo(input logic [31:0] w);
    return int'($signed(w[15:0]));
  endfunction
  function automatic int hi(input logic [31:0] w);
    return int'($signed(w[31:16]));
  endfunction
  function automatic logic [31:0] pk(input int c1, input int c0);
    return {16'(c1), 16'(c0)};
  endfunction
  function automatic int rc();
    return int'($urandom_range(6656)) - 3328;
  endfunction
  task automatic build_gold();
    for (int j = 0; j < 128; j++) begin
      int z, r0, r1;
      z = (j % 2 == 1) ? -ZT[j/2] : ZT[j/2];
      r0 = mr(mr(hi(ma[j]) * hi(mb[j])) * z) + mr(lo(ma[j]) * lo(mb[j]));
      r1 = mr(lo(ma[j]) * hi(mb[j])) + mr(hi(ma[j]) * lo(mb[j]));
      gold[j] = pk(r1, r0);
    end
  endtask
  task automatic fill_rand();
    for (int i = 0; i < 128; i++) begin
      ma[i] = pk(rc(), rc());
      mb[i] = pk(rc(), rc());
    end
  endtask
  task automatic load_ab();
    for (int i = 0; i < 128; i++) begin
      readin_a = 1'b1; readin_b = 1'b1; din_a = ma[i]; din_b = mb[i];
      tick();
    end
    readin_a = 1'b0; readin_b = 1'b0;
  endtask
  task automatic full_both();
    full_in_a = 1'b1; full_in_b = 1'b1;
    tick();
    full_in_a = 1'b0; full_in_b = 1'b0;
  endtask
  task automatic run(input int pulse_at, input int hold_at);
    cal_en = 1'b1;
    tick();
    cal_en = 1'b0;
    chk("done_fall", 32'(done), 0);
    lat = 0;
    do begin
      if (lat == hold_at) begin
        set = 1'b0;
        repeat (5) tick();
        set = 1'b1;
      end
      if (lat == pulse_at) begin
        readin_a = 1'b1; readin_b = 1'b1; full_in_a = 1'b1; cal_en = 1'b1;
        din_a = '1; din_b = '1;
      end
      tick();
      lat++;
      readin_a = 1'b0; readin_b = 1'b0; full_in_a = 1'b0; cal_en = 1'b0;
    end while (!done && lat < 400);
    chk("latency", lat, 131);
  endtask
  task automatic read_all(input string tag);
    for (int i = 0; i < 128; i++) begin
      readout = 1'b1;
      exp_q.push_back(gold[i]);
      tick();
      rd[i] = dout;
      chk(tag, dout, exp_q.pop_front());
    end
    readout = 1'b0;
    tick();
    chk("dout_hold", dout, gold[127]);
  endtask
  initial begin
    tick();
    chk("rst_done", 32'(done), 0);
    chk("rst_dout", dout, 0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 128; i++) begin
      ma[i] = pk(0, 2285);
      mb[i] = pk(7, 5);
    end
    load_ab();
    full_both();
    build_gold();
    run(-1, -1);
    read_all("t1_data");
    for (int i = 0; i < 128; i++) begin
      chk("t1_r0_mod", md(lo(rd[i])), 5);
      chk("t1_r1_mod", md(hi(rd[i])), 7);
      chk("t1_range", 32'(lo(rd[i]) > -Q && lo(rd[i]) < Q && hi(rd[i]) > -Q && hi(rd[i]) < Q), 1);
    end
    for (int i = 0; i < 128; i++) begin
      ma[i] = pk(2285, 0);
      mb[i] = pk(2285, 0);
    end
    load_ab();
    full_both();
    build_gold();
    run(-1, 50);
    read_all("t2_data");
    chk("t2_w0_r0", md(lo(rd[0])), md(-1103));
    chk("t2_w1_r0", md(lo(rd[1])), 1103);
    for (int i = 0; i < 128; i++) chk("t2_r1_zero", md(hi(rd[i])), 0);
    for (int i = 0; i < 3; i++) begin
      readin_a = 1'b1; din_a = $urandom;
      tick();
    end
    readin_a = 1'b0; full_in_a = 1'b1;
    tick();
    full_in_a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      readin_b = 1'b1; din_b = $urandom;
      tick();
    end
    readin_b = 1'b0; cal_en = 1'b1;
    tick();
    cal_en = 1'b0;
    tick();
    chk("part_done_kept", 32'(done), 1);
    full_in_b = 1'b1;
    tick();
    full_in_b = 1'b0; cal_en = 1'b1;
    tick();
    cal_en = 1'b0;
    tick();
    tick();
    chk("full_a_cleared", 32'(done), 1);
    fill_rand();
    load_ab();
    for (int i = 0; i < 5; i++) begin
      readin_a = 1'b1; din_a = ma[i];
      tick();
    end
    din_a = ma[5]; full_in_a = 1'b1; full_in_b = 1'b1;
    tick();
    readin_a = 1'b0; full_in_a = 1'b0; full_in_b = 1'b0;
    build_gold();
    run(-1, -1);
    read_all("t3_data");
    fill_rand();
    load_ab();
    full_both();
    build_gold();
    run(20, -1);
    read_all("t5_data");
    fill_rand();
    load_ab();
    full_both();
    cal_en = 1'b1;
    tick();
    cal_en = 1'b0;
    repeat (59) tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_dout", dout, 0);
    tick();
    reset = 1'b0; cal_en = 1'b1;
    tick();
    cal_en = 1'b0;
    repeat (135) tick();
    chk("rst_no_calc", 32'(done), 0);
    fill_rand();
    load_ab();
    full_both();
    build_gold();
    run(-1, -1);
    read_all("t6_data");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
